// File: rtl/calc_pkg.sv
// Shared types and constants for the keypad calculator accumulator controller.
package calc_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    HOLD  = 2'b01,
    ENTRY = 2'b11
  } calc_state_e;

  localparam logic       OP_ADD    = 1'b0;
  localparam logic       OP_SUB    = 1'b1;
  localparam logic [3:0] DIGIT_MAX = 4'd9;

  // Bit positions of the keys inside the shared edge detector.
  localparam int K_DIGIT = 0;
  localparam int K_ENTER = 1;
  localparam int K_TOTAL = 2;
  localparam int K_CLEAR = 3;

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 64'd1;
    for (int i = 0; i < n; i++) r = r * 64'd10;
    return r;
  endfunction

endpackage

// File: rtl/key_edge.sv
// N-bit rising-edge detector: inputs are registered once, then compared with
// the previous registered level so each press yields a single-cycle event.
module key_edge #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] key,
  output logic [N-1:0] evt
);

  logic [N-1:0] samp_q, samp_d;
  logic [N-1:0] prev_q, prev_d;

  always_comb begin
    samp_d = key;
    prev_d = samp_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      samp_q <= '0;
      prev_q <= '0;
    end else begin
      samp_q <= samp_d;
      prev_q <= prev_d;
    end
  end

  assign evt = samp_q & ~prev_q;

endmodule

// File: rtl/calc_accum_ctrl.sv
// Keypad calculator accumulator controller: builds a decimal entry from digit
// presses and adds/subtracts it into the accumulator on enter.
module calc_accum_ctrl
  import calc_pkg::*;
#(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             digit_key,
  input  logic [3:0]       digit_val,
  input  logic             op_sub,
  input  logic             enter,
  input  logic             total,
  input  logic             clear,
  output logic [WIDTH-1:0] acc,
  output logic [WIDTH-1:0] display,
  output logic             show,
  output logic             store_p,
  output logic             update_p,
  output logic             clear_p,
  output logic             overflow,
  output logic [1:0]       state
);

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam longint unsigned MAX_ENTRY = pow10(MAX_DIGITS) - 64'd1;

  // The largest MAX_DIGITS-digit entry must fit in the accumulator width.
  if (WIDTH < 64 && MAX_ENTRY >= (64'd1 << WIDTH)) begin : g_width_check
    $error("calc_accum_ctrl: WIDTH too small for MAX_DIGITS");
  end

  logic [3:0] evt;

  key_edge #(.N(4)) u_key_edge (
    .clk   (clk),
    .reset (reset),
    .key   ({clear, total, enter, digit_key}),
    .evt   (evt)
  );

  calc_state_e      state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] entry_q, entry_d;
  logic [CW-1:0]    count_q, count_d;
  logic             show_q, show_d;
  logic             ovf_q, ovf_d;
  logic             store_q, store_d;
  logic             update_q, update_d;
  logic             clear_q, clear_d;

  logic [WIDTH+3:0] next_entry;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic             digit_ok;

  always_comb begin
    next_entry = (WIDTH+4)'(entry_q) * (WIDTH+4)'(10) + (WIDTH+4)'(digit_val);
    sum        = {1'b0, acc_q} + {1'b0, entry_q};
    diff       = {1'b0, acc_q} - {1'b0, entry_q};
    digit_ok   = (digit_val <= DIGIT_MAX) && (count_q != CW'(MAX_DIGITS));

    state_d  = state_q;
    acc_d    = acc_q;
    entry_d  = entry_q;
    count_d  = count_q;
    show_d   = show_q;
    ovf_d    = ovf_q;
    store_d  = 1'b0;
    update_d = 1'b0;
    clear_d  = 1'b0;

    if (evt[K_TOTAL]) show_d = ~show_q;

    // Priority: clear over enter over digit; a lower-priority digit is dropped.
    if (evt[K_CLEAR]) begin
      acc_d   = '0;
      entry_d = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      show_d  = 1'b0;
      state_d = EMPTY;
      clear_d = 1'b1;
    end else if (evt[K_ENTER]) begin
      entry_d = '0;
      count_d = '0;
      state_d = HOLD;
      case (state_q)
        EMPTY: begin
          acc_d   = entry_q;
          store_d = 1'b1;
        end
        HOLD: store_d = 1'b1;
        ENTRY: begin
          update_d = 1'b1;
          if (op_sub == OP_SUB) begin
            acc_d = diff[WIDTH-1:0];
            if (diff[WIDTH]) ovf_d = 1'b1;
          end else begin
            acc_d = sum[WIDTH-1:0];
            if (sum[WIDTH]) ovf_d = 1'b1;
          end
        end
        default: begin
          state_d = EMPTY;
          acc_d   = '0;
        end
      endcase
    end else if (evt[K_DIGIT] && digit_ok) begin
      entry_d = WIDTH'(next_entry);
      count_d = count_q + CW'(1);
      if (state_q == HOLD) state_d = ENTRY;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= EMPTY;
      acc_q    <= '0;
      entry_q  <= '0;
      count_q  <= '0;
      show_q   <= 1'b0;
      ovf_q    <= 1'b0;
      store_q  <= 1'b0;
      update_q <= 1'b0;
      clear_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      entry_q  <= entry_d;
      count_q  <= count_d;
      show_q   <= show_d;
      ovf_q    <= ovf_d;
      store_q  <= store_d;
      update_q <= update_d;
      clear_q  <= clear_d;
    end
  end

  assign acc      = acc_q;
  assign display  = show_q ? acc_q : entry_q;
  assign show     = show_q;
  assign store_p  = store_q;
  assign update_p = update_q;
  assign clear_p  = clear_q;
  assign overflow = ovf_q;
  assign state    = state_q;

endmodule

// File: tb/tb_calc_accum_ctrl.sv
// Directed self-checking bench for calc_accum_ctrl (WIDTH=16, MAX_DIGITS=4).
module tb_calc_accum_ctrl;

  localparam int WIDTH = 16;

  // Key mask bits used by press(): {clear, total, enter, digit}.
  localparam logic [3:0] KD = 4'b0001;
  localparam logic [3:0] KE = 4'b0010;
  localparam logic [3:0] KT = 4'b0100;
  localparam logic [3:0] KC = 4'b1000;

  logic             clk;
  logic             reset;
  logic             digit_key;
  logic [3:0]       digit_val;
  logic             op_sub;
  logic             enter;
  logic             total;
  logic             clear;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] display;
  logic             show;
  logic             store_p;
  logic             update_p;
  logic             clear_p;
  logic             overflow;
  logic [1:0]       state;

  int n_tests;
  int n_fail;
  int cnt_store, cnt_update, cnt_clear;
  int base_store, base_update, base_clear;

  calc_accum_ctrl #(.WIDTH(WIDTH), .MAX_DIGITS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .digit_key (digit_key),
    .digit_val (digit_val),
    .op_sub    (op_sub),
    .enter     (enter),
    .total     (total),
    .clear     (clear),
    .acc       (acc),
    .display   (display),
    .show      (show),
    .store_p   (store_p),
    .update_p  (update_p),
    .clear_p   (clear_p),
    .overflow  (overflow),
    .state     (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulses are counted on the falling edge, mid-way through each cycle.
  initial begin
    cnt_store  = 0;
    cnt_update = 0;
    cnt_clear  = 0;
  end
  always @(negedge clk) begin
    if (store_p)  cnt_store  = cnt_store + 1;
    if (update_p) cnt_update = cnt_update + 1;
    if (clear_p)  cnt_clear  = cnt_clear + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic snap();
    base_store  = cnt_store;
    base_update = cnt_update;
    base_clear  = cnt_clear;
  endtask

  // Drive the selected keys high for one cycle, then let the effect settle.
  task automatic press(input logic [3:0] keys, input logic [3:0] d, input logic op);
    digit_val = d;
    op_sub    = op;
    digit_key = keys[0];
    enter     = keys[1];
    total     = keys[2];
    clear     = keys[3];
    @(negedge clk);
    digit_key = 1'b0;
    enter     = 1'b0;
    total     = 1'b0;
    clear     = 1'b0;
    idle(3);
  endtask

  task automatic digit(input logic [3:0] d);
    press(KD, d, 1'b0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    reset     = 1'b1;
    digit_key = 1'b0;
    digit_val = 4'd0;
    op_sub    = 1'b0;
    enter     = 1'b0;
    total     = 1'b0;
    clear     = 1'b0;
    idle(2);
    reset = 1'b0;
    idle(1);

    check("rst_acc", 32'(acc), 32'd0);
    check("rst_display", 32'(display), 32'd0);
    check("rst_show", 32'(show), 32'd0);
    check("rst_state", 32'(state), 32'd0);
    check("rst_pulses", {29'd0, store_p, update_p, clear_p}, 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);

    // 1,2,3 enter add from EMPTY
    digit(4'd1); digit(4'd2); digit(4'd3);
    check("entry_123_display", 32'(display), 32'd123);
    check("entry_123_state", 32'(state), 32'd0);
    snap();
    press(KE, 4'd0, 1'b0);
    check("load_acc", 32'(acc), 32'd123);
    check("load_store_cnt", 32'(cnt_store - base_store), 32'd1);
    check("load_state", 32'(state), 32'd1);
    check("load_display", 32'(display), 32'd0);

    // 123 - 77 = 46
    digit(4'd7); digit(4'd7);
    check("entry_77_state", 32'(state), 32'd3);
    check("entry_77_display", 32'(display), 32'd77);
    snap();
    press(KE, 4'd0, 1'b1);
    check("sub_acc", 32'(acc), 32'd46);
    check("sub_update_cnt", 32'(cnt_update - base_update), 32'd1);
    check("sub_overflow", 32'(overflow), 32'd0);
    check("sub_state", 32'(state), 32'd1);

    // 46 - 50 wraps to 65532 with borrow
    digit(4'd5); digit(4'd0);
    press(KE, 4'd0, 1'b1);
    check("wrap_acc", 32'(acc), 32'd65532);
    check("wrap_overflow", 32'(overflow), 32'd1);

    // invalid digit ignored, then digit limit
    digit(4'd12);
    check("bad_digit_state", 32'(state), 32'd1);
    check("bad_digit_display", 32'(display), 32'd0);
    for (int i = 0; i < 5; i++) digit(4'd9);
    check("max_digits_display", 32'(display), 32'd9999);
    check("max_digits_state", 32'(state), 32'd3);
    snap();
    press(KE, 4'd0, 1'b0);
    check("add_wrap_acc", 32'(acc), 32'd9995);
    check("add_wrap_update_cnt", 32'(cnt_update - base_update), 32'd1);
    check("overflow_sticky", 32'(overflow), 32'd1);

    // enter from HOLD with no digits
    snap();
    press(KE, 4'd0, 1'b0);
    check("hold_enter_acc", 32'(acc), 32'd9995);
    check("hold_enter_store_cnt", 32'(cnt_store - base_store), 32'd1);
    check("hold_enter_update_cnt", 32'(cnt_update - base_update), 32'd0);

    // enter held for 10 cycles gives one pulse
    snap();
    enter = 1'b1;
    idle(10);
    enter = 1'b0;
    idle(3);
    check("held_enter_store_cnt", 32'(cnt_store - base_store), 32'd1);
    check("held_enter_update_cnt", 32'(cnt_update - base_update), 32'd0);

    // total toggles display source
    press(KT, 4'd0, 1'b0);
    check("total1_show", 32'(show), 32'd1);
    check("total1_display", 32'(display), 32'd9995);
    digit(4'd4);
    check("total1_digit_display", 32'(display), 32'd9995);
    check("total1_digit_state", 32'(state), 32'd3);
    press(KT, 4'd0, 1'b0);
    check("total2_show", 32'(show), 32'd0);
    check("total2_display", 32'(display), 32'd4);

    // enter and digit together: digit dropped
    snap();
    press(KE | KD, 4'd5, 1'b0);
    check("enter_digit_acc", 32'(acc), 32'd9999);
    check("enter_digit_display", 32'(display), 32'd0);
    check("enter_digit_state", 32'(state), 32'd1);
    check("enter_digit_update_cnt", 32'(cnt_update - base_update), 32'd1);

    // clear and enter together: clear wins
    snap();
    press(KC | KE, 4'd0, 1'b0);
    check("clear_enter_clear_cnt", 32'(cnt_clear - base_clear), 32'd1);
    check("clear_enter_store_cnt", 32'(cnt_store - base_store), 32'd0);
    check("clear_enter_update_cnt", 32'(cnt_update - base_update), 32'd0);
    check("clear_enter_acc", 32'(acc), 32'd0);
    check("clear_enter_state", 32'(state), 32'd0);
    check("clear_enter_overflow", 32'(overflow), 32'd0);

    // reset during a held enter
    digit(4'd8);
    press(KE, 4'd0, 1'b0);
    press(KT, 4'd0, 1'b0);
    check("pre_reset_acc", 32'(acc), 32'd8);
    check("pre_reset_show", 32'(show), 32'd1);
    enter = 1'b1;
    idle(3);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_acc", 32'(acc), 32'd0);
    check("async_reset_show", 32'(show), 32'd0);
    check("async_reset_state", 32'(state), 32'd0);
    check("async_reset_display", 32'(display), 32'd0);
    @(negedge clk);
    snap();
    reset = 1'b0;
    idle(5);
    enter = 1'b0;
    idle(3);
    check("post_reset_store_cnt", 32'(cnt_store - base_store), 32'd1);
    check("post_reset_acc", 32'(acc), 32'd0);
    check("post_reset_state", 32'(state), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
